// File: rtl/ks_adder_pipe_if.sv
// ks_adder_pipe_if: operand/result valid/ready bundle for ks_adder_pipe.
// slave is the adder side, master is the operand source / result sink.
interface ks_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, V
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, V
    );
endinterface

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone add/sub with valid/ready flow.
// Define KS_ADDER_PIPE_OVF_EN to register signed overflow on V.
module ks_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2
) (
    input logic            clk,
    input logic            rst_n,
    ks_adder_pipe_if.slave bus
);
    localparam int L  = $clog2(WIDTH);
    localparam int NP = (L + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int NS = NP + 2;

    logic [NS-1:0]    vld;
    logic [NS-1:0]    ld;
    logic [NS-1:0]    vin;

    logic [WIDTH-1:0] g_q [NP+1];
    logic [WIDTH-1:0] p_q [NP+1];
    logic [WIDTH-1:0] r_q [NP+1];
    logic [NP:0]      c_q;

    logic [WIDTH-1:0] gc [NP+1];
    logic [WIDTH-1:0] pc [NP+1];
    logic [WIDTH-1:0] rc [NP+1];
    logic [NP:0]      cc;

    logic [WIDTH-1:0] bx, p0;
    logic [WIDTH-1:0] gt, pt, gn, pn;

    logic [WIDTH-1:0] s_q;
    logic             co_q;

    // A stage may load unless it and every stage after it is full.
    for (genvar n = 0; n < NS; n++) begin : g_ld
        assign ld[n] = ~(&vld[NS-1:n]) | bus.out_ready;
    end

    assign vin          = {vld[NS-2:0], bus.in_valid};
    assign bus.in_ready = ld[0];

    always_comb begin
        bx    = bus.Sub ? ~bus.B : bus.B;
        p0    = bus.A ^ bx;
        gt    = bus.A & bx;
        gt[0] = gt[0] | (p0[0] & bus.Cin);
        pt    = {p0[WIDTH-1:1], 1'b0};
        gn    = gt;
        pn    = pt;
        gc[0] = gt;
        pc[0] = pt;
        rc[0] = p0;
        cc[0] = bus.Cin;
        for (int s = 1; s <= NP; s++) begin
            gt = g_q[s-1];
            pt = p_q[s-1];
            for (int k = (s - 1) * LVL_PER_STG;
                 k < s * LVL_PER_STG && k < L; k++) begin
                gn = gt;
                pn = pt;
                for (int i = (1 << k); i < WIDTH; i++) begin
                    gn[i] = gt[i] | (pt[i] & gt[i-(1<<k)]);
                    // Gray cells: group P is dead once span reaches bit 0.
                    if (i >= (2 << k))
                        pn[i] = pt[i] & pt[i-(1<<k)];
                end
                gt = gn;
                pt = pn;
            end
            gc[s] = gt;
            pc[s] = pt;
            rc[s] = r_q[s-1];
            cc[s] = c_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            c_q  <= '0;
            s_q  <= '0;
            co_q <= 1'b0;
            for (int s = 0; s <= NP; s++) begin
                g_q[s] <= '0;
                p_q[s] <= '0;
                r_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NS; s++)
                if (ld[s]) vld[s] <= vin[s];
            for (int s = 0; s <= NP; s++) begin
                if (ld[s] && vin[s]) begin
                    g_q[s] <= gc[s];
                    p_q[s] <= pc[s];
                    r_q[s] <= rc[s];
                    c_q[s] <= cc[s];
                end
            end
            if (ld[NS-1] && vin[NS-1]) begin
                s_q  <= r_q[NP] ^ {g_q[NP][WIDTH-2:0], c_q[NP]};
                co_q <= g_q[NP][WIDTH-1];
            end
        end
    end

`ifdef KS_ADDER_PIPE_OVF_EN
    logic v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v_q <= 1'b0;
        else if (ld[NS-1] && vin[NS-1])
            v_q <= g_q[NP][WIDTH-1] ^ g_q[NP][WIDTH-2];
    end

    assign bus.V = v_q;
`else
    assign bus.V = 1'b0;
`endif

    assign bus.out_valid = vld[NS-1];
    assign bus.S         = s_q;
    assign bus.Cout      = co_q;
endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: directed + random checks of ks_adder_pipe
// against an arithmetic scoreboard model (32-bit and 8-bit builds).
module tb_ks_adder_pipe;
    typedef struct packed {
        logic        v;
        logic        c;
        logic [63:0] s;
    } res_t;

    logic clk;
    logic rst_n;
    int   nvec;
    int   miscnt;
    int   lat;
    int   guard;
    logic [31:0] hold;
    res_t q32[$];
    res_t q8[$];

    ks_adder_pipe_if #(.WIDTH(32)) b32();
    ks_adder_pipe_if #(.WIDTH(8))  b8();

    ks_adder_pipe #(.WIDTH(32), .LVL_PER_STG(2)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    ks_adder_pipe #(.WIDTH(8), .LVL_PER_STG(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input int w,
                                   input logic [63:0] a, b,
                                   input logic cin, sub);
        logic [64:0] sum;
        logic [63:0] m, bp;
        res_t        r;
        m    = (64'd1 << w) - 64'd1;
        bp   = (sub ? ~b : b) & m;
        sum  = {1'b0, a & m} + {1'b0, bp} + 65'(cin);
        r.s  = sum[63:0] & m;
        r.c  = sum[w];
`ifdef KS_ADDER_PIPE_OVF_EN
        r.v  = (a[w-1] == bp[w-1]) && (r.s[w-1] != a[w-1]);
`else
        r.v  = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, exp);
        nvec++;
        assert (got === exp) else begin
            miscnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step32(input logic iv, ordy,
                          input logic [31:0] a, b,
                          input logic cin, sub);
        res_t e;
        b32.in_valid  = iv;
        b32.out_ready = ordy;
        b32.A   = a;
        b32.B   = b;
        b32.Cin = cin;
        b32.Sub = sub;
        #1;
        if (b32.out_valid && b32.out_ready) begin
            chk("w32_result_expected", 64'(q32.size() != 0), 1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                chk("w32_S", 64'(b32.S), e.s);
                chk("w32_Cout", 64'(b32.Cout), 64'(e.c));
                chk("w32_V", 64'(b32.V), 64'(e.v));
            end
        end
        if (b32.in_valid && b32.in_ready)
            q32.push_back(model(32, 64'(a), 64'(b), cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic iv, ordy,
                         input logic [7:0] a, b,
                         input logic cin, sub);
        res_t e;
        b8.in_valid  = iv;
        b8.out_ready = ordy;
        b8.A   = a;
        b8.B   = b;
        b8.Cin = cin;
        b8.Sub = sub;
        #1;
        if (b8.out_valid && b8.out_ready) begin
            chk("w8_result_expected", 64'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("w8_S", 64'(b8.S), e.s);
                chk("w8_Cout", 64'(b8.Cout), 64'(e.c));
                chk("w8_V", 64'(b8.V), 64'(e.v));
            end
        end
        if (b8.in_valid && b8.in_ready)
            q8.push_back(model(8, 64'(a), 64'(b), cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic rnd32(input logic iv, ordy);
        step32(iv, ordy, $urandom, $urandom,
               1'($urandom), 1'($urandom));
    endtask

    task automatic drain32();
        guard = 0;
        while (q32.size() != 0 && guard < 50) begin
            step32(0, 1, 0, 0, 0, 0);
            guard++;
        end
        chk("w32_drained", 64'(q32.size()), 0);
    endtask

    task automatic measure32(input logic [31:0] a, b,
                             input logic cin, sub);
        step32(1, 1, a, b, cin, sub);
        lat = 1;
        while (!b32.out_valid && lat < 20) begin
            step32(0, 1, 0, 0, 0, 0);
            lat++;
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        nvec   = 0;
        miscnt = 0;
        b32.in_valid = 0; b32.out_ready = 0;
        b32.A = 0; b32.B = 0; b32.Cin = 0; b32.Sub = 0;
        b8.in_valid = 0;  b8.out_ready = 0;
        b8.A = 0;  b8.B = 0;  b8.Cin = 0;  b8.Sub = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(b32.out_valid), 0);
        chk("rst_S", 64'(b32.S), 0);
        chk("rst_Cout", 64'(b32.Cout), 0);
        chk("rst_V", 64'(b32.V), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(b32.in_ready), 1);

        measure32(32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        chk("add_latency", 64'(lat), 5);
        chk("add_S", 64'(b32.S), 64'h0);
        chk("add_Cout", 64'(b32.Cout), 1);
        chk("add_V", 64'(b32.V), 0);
        drain32();

        measure32(32'h8000_0000, 32'h0000_0001, 1, 1);
        chk("sub_latency", 64'(lat), 5);
        chk("sub_S", 64'(b32.S), 64'h7FFF_FFFF);
        chk("sub_Cout", 64'(b32.Cout), 1);
`ifdef KS_ADDER_PIPE_OVF_EN
        chk("sub_V", 64'(b32.V), 1);
`else
        chk("sub_V", 64'(b32.V), 0);
`endif
        drain32();

        for (int i = 0; i < 1000; i++) rnd32(1, 1);
        chk("stream_in_flight", 64'(q32.size()), 5);
        drain32();

        for (int i = 0; i < 10; i++) rnd32(1, 0);
        chk("stall_accepted", 64'(q32.size()), 5);
        chk("stall_in_ready", 64'(b32.in_ready), 0);
        chk("stall_out_valid", 64'(b32.out_valid), 1);
        hold = b32.S;
        for (int i = 0; i < 3; i++) rnd32(1, 0);
        chk("stall_S_hold", 64'(b32.S), 64'(hold));
        chk("stall_S_oldest", 64'(b32.S), q32[0].s);
        rnd32(1, 1);
        chk("full_accept_drain", 64'(q32.size()), 5);
        drain32();

        for (int i = 0; i < 400; i++)
            rnd32(1'($urandom), $urandom_range(0, 3) != 0);
        drain32();

        for (int i = 0; i < 3; i++) rnd32(1, 0);
        for (int i = 0; i < 4; i++) step32(0, 0, 0, 0, 0, 0);
        chk("pre_rst_out_valid", 64'(b32.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(b32.out_valid), 0);
        chk("mid_rst_S", 64'(b32.S), 0);
        chk("mid_rst_Cout", 64'(b32.Cout), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q32.delete();
        #1;
        chk("post_rst_in_ready", 64'(b32.in_ready), 1);
        for (int i = 0; i < 12; i++) step32(0, 1, 0, 0, 0, 0);
        chk("post_rst_no_stale", 64'(b32.out_valid), 0);

        step8(1, 1, 8'h7F, 8'h01, 0, 0);
        lat = 1;
        while (!b8.out_valid && lat < 20) begin
            step8(0, 1, 0, 0, 0, 0);
            lat++;
        end
        chk("w8_latency", 64'(lat), 3);
        step8(0, 1, 0, 0, 0, 0);
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                step8(1, 1, 8'(a), 8'(b),
                      1'(a + b), 1'((a + b) >> 1));
        chk("w8_in_flight", 64'(q8.size()), 3);
        guard = 0;
        while (q8.size() != 0 && guard < 50) begin
            step8(0, 1, 0, 0, 0, 0);
            guard++;
        end
        chk("w8_drained", 64'(q8.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, miscnt);
        $finish;
    end
endmodule
